// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: opcodes, ALU input-select
// codes, FSM states and command-word field positions.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NOT   = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MULT  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } seqState_t;

    // Command word layout: {use_acc, op, a, b}
    localparam int CMD_W           = 20;
    localparam int CMD_B_LSB       = 0;
    localparam int CMD_A_LSB       = 8;
    localparam int CMD_OP_LSB      = 16;
    localparam int CMD_USE_ACC_BIT = 19;

    // CLEAR (7) has no output-select bit, so it naturally maps to all zeros.
    function automatic logic [6:0] opOneHot(input logic [2:0] op);
        logic [6:0] oh;
        oh = '0;
        for (int k = 0; k < 7; k++) begin
            if (op == 3'(k)) oh[k] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Command FIFO for the ALU sequencer: power-of-two depth, async reset,
// head word visible combinationally on rdData.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      cnt;
    logic             doPush;
    logic             doPop;

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign rdData = mem[rdPtr];
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the 8-bit accumulator ALU: queues commands, drives
// the ALU lines, captures the result and returns it over a valid/ready port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a queued command; pops head and loads ALU lines
//   ST_ISSUE | ALU lines stable; ALU registers them at the end of this cycle
//   ST_CAPT  | ALU result valid; capture result/ovf and shadow accumulator
//   ST_RESP  | res_valid high until res_ready
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_use_acc,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [2:0] alu_in_sel,
    output logic [6:0] alu_out_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_ovf,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_ovf,
    output logic       busy
);

    seqState_t               state;
    logic [CMD_W-1:0]        cmdWord;
    logic [CMD_W-1:0]        fifoHead;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [$clog2(DEPTH):0]  fifoCount;
    logic                    fifoPush;
    logic                    fifoPop;
    logic                    headUseAcc;
    logic [2:0]              headOp;
    logic [7:0]              headA;
    logic [7:0]              headB;
    logic [2:0]              issueOp;
    logic [7:0]              accReg;
    logic [7:0]              captData;

    assign cmdWord   = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
    assign cmd_ready = !fifoFull;
    assign fifoPush  = cmd_valid && cmd_ready;
    assign fifoPop   = (state == ST_IDLE) && !fifoEmpty;
    assign busy      = (state != ST_IDLE) || (fifoCount != '0);

    assign headUseAcc = fifoHead[CMD_USE_ACC_BIT];
    assign headOp     = fifoHead[CMD_OP_LSB +: 3];
    assign headA      = fifoHead[CMD_A_LSB +: 8];
    assign headB      = fifoHead[CMD_B_LSB +: 8];

    assign captData = (issueOp == OP_CLEAR) ? 8'h00 : alu_result;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifoPush),
        .pop    (fifoPop),
        .wrData (cmdWord),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            issueOp     <= OP_AND;
            accReg      <= '0;
            alu_num1    <= '0;
            alu_num2    <= '0;
            alu_in_sel  <= IN_SEL_LOAD;
            alu_out_sel <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // ALU lines only ever change here, on the way into ISSUE.
                    if (!fifoEmpty) begin
                        issueOp     <= headOp;
                        alu_num1    <= headUseAcc ? accReg : headA;
                        alu_num2    <= headB;
                        alu_in_sel  <= (headOp == OP_CLEAR) ? IN_SEL_RESET : IN_SEL_LOAD;
                        alu_out_sel <= opOneHot(headOp);
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_in_sel <= IN_SEL_LOAD;
                    state      <= ST_CAPT;
                end
                ST_CAPT: begin
                    res_data  <= captData;
                    accReg    <= captData;
                    res_ovf   <= (issueOp == OP_MULT) && alu_ovf;
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end that sits directly upstream of the 8-bit accumulator ALU. It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. For each request it drives the ALU's operand, input-select and one-hot output-select lines, captures the ALU result and overflow one cycle later, and returns them over a second valid/ready handshake. It also keeps a shadow accumulator so commands can chain on the previous result.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO not full (combinational from count).
- `cmd_op` in 3: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR.
- `cmd_use_acc` in 1: use shadow accumulator instead of `cmd_a` as operand A.
- `cmd_a`, `cmd_b` in 8 each: operands.
- `alu_num1`, `alu_num2` out 8 each: registered operands to ALU.
- `alu_in_sel` out 3: 3'b100 persist, 3'b010 load, 3'b001 reset. Persist is never driven.
- `alu_out_sel` out 7: one-hot, bit k = opcode k.
- `alu_result` in 8: ALU output value.
- `alu_ovf` in 1: ALU multiplier overflow.
- `res_valid` out 1; `res_ready` in 1.
- `res_data` out 8; `res_ovf` out 1.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- Command word: {use_acc, op, a, b}, 20 bits. It is pushed when `cmd_valid && cmd_ready`.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the issue registers and go to ISSUE.
  - ISSUE: drive the issue registers onto the ALU lines; go to CAPT.
  - CAPT: sample `alu_result` and `alu_ovf` into the result registers; go to RESP.
  - RESP: hold `res_valid` high until `res_ready`, then go to IDLE.
- Operand drive:
  - `alu_num1` = shadow acc if use_acc, else a.
  - `alu_num2` = b.
  - `alu_in_sel` = load (3'b010); CLEAR drives reset (3'b001) instead.
  - `alu_out_sel` = 1<<op; CLEAR drives 7'b0.
- Drive-line hold: ALU lines change only on entry to ISSUE. Outside ISSUE they hold their last values, except that `alu_in_sel` reverts to load. This keeps the ALU registers stable.
- Capture rules:
  - `res_data` = `alu_result`; for CLEAR it is forced to 8'h00.
  - `res_ovf` = `alu_ovf` only for MULT, else 0.
  - The shadow acc is updated with `res_data` in CAPT.
- Arithmetic: 8-bit, modulo 256. There is no carry or borrow output. SUB 3−5 returns 8'hFE.
- FIFO boundaries:
  - Pushes are refused when full (`cmd_ready`=0).
  - Push and pop in the same cycle leave the count unchanged.
  - There is no bypass: an empty FIFO always costs the IDLE cycle.
- Reset values: FIFO empty, FSM IDLE, `cmd_ready`=1, `alu_num1`/`alu_num2`=0, `alu_in_sel`=3'b010, `alu_out_sel`=0, `res_valid`=0, `res_data`=0, `res_ovf`=0, shadow acc=0, `busy`=0.
- Reset mid-operation: an in-flight command and all queued commands are discarded; no response is produced.

## Timing
- Command accepted at edge E0: IDLE at E1 (pop) → ISSUE at E2 → CAPT at E3 → `res_valid` high after E3.
- Minimum accept-to-response latency is 3 cycles.
- Minimum per-command period is 4 cycles, plus any `res_ready` stall.
- ALU contract: the ALU registers its inputs at the edge ending ISSUE, and `alu_result` is combinationally valid during CAPT.
- While `res_valid` is high, `res_data`/`res_ovf` are stable until the handshake completes.
- Backpressure: while stalled in RESP, the FIFO keeps accepting until full.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode constants;
  - `alu_in_sel` encodings (PERSIST/LOAD/RESET);
  - FSM state encodings (2 bits: IDLE, ISSUE, CAPT, RESP);
  - command-word field offsets.
- Sub-module `alu_cmd_fifo`: parameterised-depth synchronous FIFO with async reset, providing push/pop/full/empty/count.
- The top level contains the FSM, issue registers, result registers and shadow acc.

## Test plan
- ADD a=5, b=3, `res_ready`=1 → `alu_out_sel`=7'b0010000 and `alu_in_sel`=3'b010 in ISSUE; `res_data`=8, `res_ovf`=0, `res_valid` exactly 3 cycles after accept.
- MULT a=16, b=16 with model ALU asserting ovf → `res_data`=8'h00, `res_ovf`=1. SUB 3−5 → 8'hFE, `res_ovf`=0 even if `alu_ovf` is stuck high.
- Accumulator chain:
  - ADD 10+0, then ADD use_acc b=7 → `alu_num1`=10, result 17;
  - then CLEAR → `alu_in_sel`=3'b001, result 0;
  - then ADD use_acc b=1 → result 1.
- Backpressure: hold `res_ready`=0 and push 6 commands → `cmd_ready` drops after DEPTH+1 accepts (4 queued plus 1 in RESP). Release → results return in order, with no loss or duplication.
- Push during pop with FIFO partially full → count unchanged, order preserved.
- Assert `rst` during CAPT with 2 queued → all outputs at reset values immediately, no response emitted. After release, a new ADD 1+1 returns 2.
